// File: rtl/mic1_io_bridge_if.sv
// rtl/mic1_io_bridge_if.sv - mic1 data port, memory port A and host character streams
interface mic1_io_bridge_if;
   logic        cpu_read;
   logic        cpu_write;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic [31:0] cpu_rdata;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] mem_rdata;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        rx_ready;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        tx_ready;

   // Bridge side
   modport slave (
      input  cpu_read, cpu_write, cpu_addr, cpu_wdata,
      output cpu_rdata,
      output mem_read, mem_write,
      input  mem_rdata,
      input  rx_valid, rx_data,
      output rx_ready,
      output tx_valid, tx_data,
      input  tx_ready
   );

   // CPU / memory / host side
   modport master (
      output cpu_read, cpu_write, cpu_addr, cpu_wdata,
      input  cpu_rdata,
      input  mem_read, mem_write,
      output mem_rdata,
      output rx_valid, rx_data,
      input  rx_ready,
      input  tx_valid, tx_data,
      output tx_ready
   );
endinterface

// File: rtl/mic1_io_bridge.sv
// rtl/mic1_io_bridge.sv - memory-mapped character IO bridge between mic1 and a host stream
module mic1_io_bridge #(
   parameter int unsigned RX_DEPTH  = 4,
   parameter int unsigned TX_DEPTH  = 4,
   parameter logic [31:0] DATA_ADDR = 32'hFFFFFFFD,
   parameter logic [31:0] STAT_ADDR = 32'hFFFFFFFC
) (
   input logic               clk,
   input logic               reset,
   mic1_io_bridge_if.slave   bus
);

   localparam int unsigned RX_AW = $clog2(RX_DEPTH);
   localparam int unsigned TX_AW = $clog2(TX_DEPTH);
   localparam logic [RX_AW:0] RX_FULL_CNT = (RX_AW + 1)'(RX_DEPTH);
   localparam logic [TX_AW:0] TX_FULL_CNT = (TX_AW + 1)'(TX_DEPTH);

   // Storage and state
   logic [7:0]       rx_mem_q [RX_DEPTH];
   logic [7:0]       tx_mem_q [TX_DEPTH];
   logic [RX_AW-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
   logic [TX_AW-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
   logic [RX_AW:0]   rx_cnt_q, rx_cnt_d;
   logic [TX_AW:0]   tx_cnt_q, tx_cnt_d;
   logic             rx_ovf_q, rx_ovf_d;
   logic             tx_drop_q, tx_drop_d;
   logic             io_sel_q, io_sel_d;
   logic [31:0]      rdata_q, rdata_d;

   // Decode and flow-control terms
   logic        hit_data, hit_stat, io_hit;
   logic        data_rd, stat_rd, data_wr, stat_wr;
   logic        rx_full, rx_empty, tx_full, tx_empty;
   logic        rx_push, rx_pop, tx_push, tx_pop;
   logic [31:0] status;
   logic        unused_wdata;

   assign hit_data = (bus.cpu_addr == DATA_ADDR);
   assign hit_stat = (bus.cpu_addr == STAT_ADDR);
   assign io_hit   = hit_data | hit_stat;

   // A simultaneous read and write at an IO address behaves as a write only.
   assign data_wr = bus.cpu_write & hit_data;
   assign stat_wr = bus.cpu_write & hit_stat;
   assign data_rd = bus.cpu_read & ~bus.cpu_write & hit_data;
   assign stat_rd = bus.cpu_read & ~bus.cpu_write & hit_stat;

   assign bus.mem_read  = bus.cpu_read  & ~io_hit;
   assign bus.mem_write = bus.cpu_write & ~io_hit;

   assign rx_full  = (rx_cnt_q == RX_FULL_CNT);
   assign rx_empty = (rx_cnt_q == '0);
   assign tx_full  = (tx_cnt_q == TX_FULL_CNT);
   assign tx_empty = (tx_cnt_q == '0);

   // RX pushes are refused while full, so a same-cycle pop on a full RX only drains.
   assign rx_push = bus.rx_valid & ~rx_full;
   assign rx_pop  = data_rd & ~rx_empty;
   assign tx_push = data_wr & ~tx_full;
   assign tx_pop  = ~tx_empty & bus.tx_ready;

   assign bus.rx_ready  = ~rx_full;
   assign bus.tx_valid  = ~tx_empty;
   assign bus.tx_data   = tx_empty ? 8'h00 : tx_mem_q[tx_rd_q];
   assign bus.cpu_rdata = io_sel_q ? rdata_q : bus.mem_rdata;

   assign status = {27'b0, tx_drop_q, tx_empty, rx_ovf_q, tx_full, ~rx_empty};

   assign unused_wdata = ^{bus.cpu_wdata[31:8], bus.cpu_wdata[3], bus.cpu_wdata[1:0]};

   // Next-state for pointers, counts, sticky flags and the read-data register
   always_comb begin
      rx_wr_d   = rx_wr_q;
      rx_rd_d   = rx_rd_q;
      rx_cnt_d  = rx_cnt_q;
      tx_wr_d   = tx_wr_q;
      tx_rd_d   = tx_rd_q;
      tx_cnt_d  = tx_cnt_q;
      rx_ovf_d  = rx_ovf_q;
      tx_drop_d = tx_drop_q;
      io_sel_d  = data_rd | stat_rd;
      rdata_d   = rdata_q;

      if (rx_push) rx_wr_d = rx_wr_q + 1'b1;
      if (rx_pop)  rx_rd_d = rx_rd_q + 1'b1;
      case ({rx_push, rx_pop})
         2'b10:   rx_cnt_d = rx_cnt_q + 1'b1;
         2'b01:   rx_cnt_d = rx_cnt_q - 1'b1;
         default: rx_cnt_d = rx_cnt_q;
      endcase

      if (tx_push) tx_wr_d = tx_wr_q + 1'b1;
      if (tx_pop)  tx_rd_d = tx_rd_q + 1'b1;
      case ({tx_push, tx_pop})
         2'b10:   tx_cnt_d = tx_cnt_q + 1'b1;
         2'b01:   tx_cnt_d = tx_cnt_q - 1'b1;
         default: tx_cnt_d = tx_cnt_q;
      endcase

      // Clears come first so a fresh event in the same cycle still sticks.
      if (stat_wr && bus.cpu_wdata[2]) rx_ovf_d  = 1'b0;
      if (stat_wr && bus.cpu_wdata[4]) tx_drop_d = 1'b0;
      if (bus.rx_valid && rx_full)     rx_ovf_d  = 1'b1;
      if (data_wr && tx_full)          tx_drop_d = 1'b1;

      if (stat_rd)
         rdata_d = status;
      else if (data_rd)
         rdata_d = rx_empty ? 32'h0 : {24'b0, rx_mem_q[rx_rd_q]};
   end

   // State registers; FIFO storage itself needs no reset since counts gate it
   always_ff @(posedge clk) begin
      if (rx_push) rx_mem_q[rx_wr_q] <= bus.rx_data;
      if (tx_push) tx_mem_q[tx_wr_q] <= bus.cpu_wdata[7:0];
      if (reset) begin
         rx_wr_q   <= '0;
         rx_rd_q   <= '0;
         rx_cnt_q  <= '0;
         tx_wr_q   <= '0;
         tx_rd_q   <= '0;
         tx_cnt_q  <= '0;
         rx_ovf_q  <= 1'b0;
         tx_drop_q <= 1'b0;
         io_sel_q  <= 1'b0;
         rdata_q   <= 32'h0;
      end else begin
         rx_wr_q   <= rx_wr_d;
         rx_rd_q   <= rx_rd_d;
         rx_cnt_q  <= rx_cnt_d;
         tx_wr_q   <= tx_wr_d;
         tx_rd_q   <= tx_rd_d;
         tx_cnt_q  <= tx_cnt_d;
         rx_ovf_q  <= rx_ovf_d;
         tx_drop_q <= tx_drop_d;
         io_sel_q  <= io_sel_d;
         rdata_q   <= rdata_d;
      end
   end

endmodule
